// File: rtl/lsu_dmem_if.sv
// LSU-to-data-memory request/response bus: a combinational read channel
// and a posted write channel.
interface lsu_dmem_if;
   logic        mem_ren;
   logic [63:0] mem_raddr;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        mem_wen;
   logic [63:0] mem_waddr;
   logic [63:0] mem_wdata;

   modport master (
      output mem_ren,
      output mem_raddr,
      input  mem_rvalid,
      input  mem_rdata,
      output mem_wen,
      output mem_waddr,
      output mem_wdata
   );

   modport slave (
      input  mem_ren,
      input  mem_raddr,
      output mem_rvalid,
      output mem_rdata,
      input  mem_wen,
      input  mem_waddr,
      input  mem_wdata
   );
endinterface

// File: rtl/lsu_dmem.sv
// Single-ported 64-bit data memory behind the LSU: zero-latency read with
// write-first forwarding, clocked writes, preload port, sticky error capture and access counters.
module lsu_dmem #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [63:0] BASE_ADDR   = 64'h0
) (
   input  logic                           clk,
   input  logic                           rst,
   lsu_dmem_if.slave                      bus,
   input  logic                           init_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] init_addr,
   input  logic [63:0]                    init_data,
   output logic                           err,
   output logic [63:0]                    err_addr,
   output logic [31:0]                    rd_count,
   output logic [31:0]                    wr_count
);

   localparam int unsigned AW   = $clog2(DEPTH_WORDS);
   localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 3;

   // Offset-based bound test avoids overflow when BASE_ADDR + SPAN wraps 2^64.
   function automatic logic addr_legal(input logic [63:0] addr, input logic [63:0] off);
      return (addr[2:0] == 3'b000) && (addr >= BASE_ADDR) && (off < SPAN);
   endfunction

   logic [63:0]   mem_r [DEPTH_WORDS];
   logic          err_r;
   logic [63:0]   err_addr_r;
   logic [31:0]   rd_count_r;
   logic [31:0]   wr_count_r;

   logic [63:0]   roff_s;
   logic [63:0]   woff_s;
   logic [AW-1:0] ridx_s;
   logic [AW-1:0] widx_s;
   logic          rlegal_s;
   logic          wlegal_s;
   logic          wr_accept_s;
   logic          ill_r_s;
   logic          ill_w_s;
   logic          rvalid_s;
   logic [63:0]   rdata_s;

   // Address decode and request qualification for both channels.
   always_comb begin
      roff_s      = bus.mem_raddr - BASE_ADDR;
      woff_s      = bus.mem_waddr - BASE_ADDR;
      ridx_s      = roff_s[AW+2:3];
      widx_s      = woff_s[AW+2:3];
      rlegal_s    = addr_legal(bus.mem_raddr, roff_s);
      wlegal_s    = addr_legal(bus.mem_waddr, woff_s);
      wr_accept_s = !rst && bus.mem_wen && wlegal_s && !init_en;
      ill_r_s     = !rst && bus.mem_ren && !rlegal_s;
      ill_w_s     = !rst && bus.mem_wen && !wlegal_s;
   end

   // Combinational read with write-first forwarding from an accepted same-index write.
   always_comb begin
      rvalid_s = 1'b0;
      rdata_s  = 64'h0;
      if (!rst && bus.mem_ren && rlegal_s) begin
         rvalid_s = 1'b1;
         if (wr_accept_s && (widx_s == ridx_s)) begin
            rdata_s = bus.mem_wdata;
         end else begin
            rdata_s = mem_r[ridx_s];
         end
      end else begin
         rvalid_s = 1'b0;
         rdata_s  = 64'h0;
      end
   end

   assign bus.mem_rvalid = rvalid_s;
   assign bus.mem_rdata  = rdata_s;

   // Array update: preload has priority and works even while rst is held.
   always_ff @(posedge clk) begin
      if (init_en) begin
         mem_r[init_addr] <= init_data;
      end else if (wr_accept_s) begin
         mem_r[widx_s] <= bus.mem_wdata;
      end
   end

   // Sticky error capture; a bad write address wins over a bad read address.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_r      <= 1'b0;
         err_addr_r <= 64'h0;
      end else if (!err_r && ill_w_s) begin
         err_r      <= 1'b1;
         err_addr_r <= bus.mem_waddr;
      end else if (!err_r && ill_r_s) begin
         err_r      <= 1'b1;
         err_addr_r <= bus.mem_raddr;
      end
   end

   // Access counters, free-running modulo 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count_r <= 32'd0;
         wr_count_r <= 32'd0;
      end else begin
         if (rvalid_s) begin
            rd_count_r <= rd_count_r + 32'd1;
         end
         if (wr_accept_s) begin
            wr_count_r <= wr_count_r + 32'd1;
         end
      end
   end

   assign err      = err_r;
   assign err_addr = err_addr_r;
   assign rd_count = rd_count_r;
   assign wr_count = wr_count_r;

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed self-checking bench for lsu_dmem with a non-zero base and a
// small array so the upper bound and index truncation are exercised.
module tb_lsu_dmem;
   localparam int unsigned DEPTH = 16;
   localparam logic [63:0] BASE  = 64'h1000;

   logic        clk;
   logic        rst;
   logic        init_en;
   logic [3:0]  init_addr;
   logic [63:0] init_data;
   logic        err;
   logic [63:0] err_addr;
   logic [31:0] rd_count;
   logic [31:0] wr_count;
   int          errors;
   int          checks;

   lsu_dmem_if bus ();

   lsu_dmem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .init_en   (init_en),
      .init_addr (init_addr),
      .init_data (init_data),
      .err       (err),
      .err_addr  (err_addr),
      .rd_count  (rd_count),
      .wr_count  (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.mem_ren   = 1'b0;
      bus.mem_raddr = 64'h0;
      bus.mem_wen   = 1'b0;
      bus.mem_waddr = 64'h0;
      bus.mem_wdata = 64'h0;
      init_en       = 1'b0;
      init_addr     = 4'd0;
      init_data     = 64'h0;
   endtask

   task automatic set_rd(input logic [63:0] a);
      bus.mem_ren   = 1'b1;
      bus.mem_raddr = a;
   endtask

   task automatic set_wr(input logic [63:0] a, input logic [63:0] d);
      bus.mem_wen   = 1'b1;
      bus.mem_waddr = a;
      bus.mem_wdata = d;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   // Clock edge then step off it before sampling registered outputs.
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Preload under reset plus an LSU read that must be suppressed.
      init_en = 1'b1; init_addr = 4'd5; init_data = 64'hDEAD_BEEF_0000_0005;
      set_rd(BASE + 64'd40);
      settle();
      check_eq("rst_rvalid", 64'(bus.mem_rvalid), 64'd0);
      check_eq("rst_rdata", bus.mem_rdata, 64'h0);
      tick();
      check_eq("rst_err", 64'(err), 64'd0);
      check_eq("rst_err_addr", err_addr, 64'h0);
      check_eq("rst_rd_count", 64'(rd_count), 64'd0);
      check_eq("rst_wr_count", 64'(wr_count), 64'd0);
      check_eq("idle_rdata", bus.mem_rdata, 64'h0);
      rst = 1'b0;

      set_rd(BASE + 64'd40);
      settle();
      check_eq("preload_rvalid", 64'(bus.mem_rvalid), 64'd1);
      check_eq("preload_rdata", bus.mem_rdata, 64'hDEAD_BEEF_0000_0005);
      tick();
      check_eq("preload_rd_count", 64'(rd_count), 64'd1);

      // Write then read back.
      set_wr(BASE + 64'd16, 64'h1234);
      tick();
      check_eq("wr1_wr_count", 64'(wr_count), 64'd1);
      set_rd(BASE + 64'd16);
      settle();
      check_eq("wr1_rdata", bus.mem_rdata, 64'h1234);
      tick();

      // Same-cycle forwarding.
      set_rd(BASE + 64'd24);
      set_wr(BASE + 64'd24, 64'hAB);
      settle();
      check_eq("fwd_rdata", bus.mem_rdata, 64'hAB);
      tick();
      check_eq("fwd_rd_count", 64'(rd_count), 64'd3);
      check_eq("fwd_wr_count", 64'(wr_count), 64'd2);

      // Paired store then paired load.
      set_wr(BASE, 64'd1);
      tick();
      tick();
      set_wr(BASE + 64'd8, 64'd2);
      tick();
      set_rd(BASE);
      settle();
      check_eq("pair_rd0", bus.mem_rdata, 64'd1);
      tick();
      set_rd(BASE + 64'd8);
      settle();
      check_eq("pair_rd1", bus.mem_rdata, 64'd2);
      tick();
      check_eq("pair_wr_count", 64'(wr_count), 64'd4);
      check_eq("pair_rd_count", 64'(rd_count), 64'd5);

      // Read and write to different indices in one cycle.
      set_rd(BASE + 64'd16);
      set_wr(BASE + 64'd32, 64'h55);
      settle();
      check_eq("dual_rdata", bus.mem_rdata, 64'h1234);
      tick();
      set_rd(BASE + 64'd32);
      settle();
      check_eq("dual_wr_visible", bus.mem_rdata, 64'h55);
      tick();

      // Held write is counted every accepted cycle.
      set_wr(BASE + 64'd32, 64'h55);
      tick();
      set_wr(BASE + 64'd32, 64'h55);
      tick();
      check_eq("repeat_wr_count", 64'(wr_count), 64'd7);
      check_eq("repeat_rd_count", 64'(rd_count), 64'd7);

      // Misaligned read: rejected, error captured.
      set_rd(BASE + 64'd3);
      settle();
      check_eq("misal_rvalid", 64'(bus.mem_rvalid), 64'd0);
      check_eq("misal_rdata", bus.mem_rdata, 64'h0);
      tick();
      check_eq("misal_err", 64'(err), 64'd1);
      check_eq("misal_err_addr", err_addr, BASE + 64'd3);
      check_eq("misal_rd_count", 64'(rd_count), 64'd7);

      // Out-of-range write aliases index 0 when truncated; must not land.
      set_wr(BASE + 64'd128, 64'hFF);
      tick();
      check_eq("oob_err_addr", err_addr, BASE + 64'd3);
      check_eq("oob_wr_count", 64'(wr_count), 64'd7);
      set_rd(BASE);
      settle();
      check_eq("oob_array", bus.mem_rdata, 64'd1);
      tick();

      // Below-base read and last legal word.
      set_rd(BASE - 64'd8);
      settle();
      check_eq("below_rvalid", 64'(bus.mem_rvalid), 64'd0);
      tick();
      set_wr(BASE + 64'd120, 64'h77);
      tick();
      set_rd(BASE + 64'd120);
      settle();
      check_eq("last_rdata", bus.mem_rdata, 64'h77);
      tick();
      check_eq("last_rd_count", 64'(rd_count), 64'd9);
      check_eq("last_wr_count", 64'(wr_count), 64'd8);

      // Init beats a coincident LSU write.
      init_en = 1'b1; init_addr = 4'd2; init_data = 64'd7;
      set_wr(BASE + 64'd16, 64'd9);
      tick();
      check_eq("conf_wr_count", 64'(wr_count), 64'd8);
      set_rd(BASE + 64'd16);
      settle();
      check_eq("conf_rdata", bus.mem_rdata, 64'd7);
      tick();

      // Reset mid-stream with a concurrent request.
      rst = 1'b1;
      set_rd(BASE + 64'd8);
      set_wr(BASE, 64'h99);
      settle();
      check_eq("mid_rst_rvalid", 64'(bus.mem_rvalid), 64'd0);
      tick();
      rst = 1'b0;
      check_eq("mid_rst_err", 64'(err), 64'd0);
      check_eq("mid_rst_err_addr", err_addr, 64'h0);
      check_eq("mid_rst_rd_count", 64'(rd_count), 64'd0);
      check_eq("mid_rst_wr_count", 64'(wr_count), 64'd0);
      set_rd(BASE);
      settle();
      check_eq("retain_w0", bus.mem_rdata, 64'd1);
      tick();
      set_rd(BASE + 64'd16);
      settle();
      check_eq("retain_w2", bus.mem_rdata, 64'd7);
      tick();
      check_eq("retain_rd_count", 64'(rd_count), 64'd2);

      // Both channels illegal: write address captured, then frozen.
      set_rd(BASE + 64'd5);
      set_wr(BASE + 64'h2000, 64'h1);
      tick();
      check_eq("both_err", 64'(err), 64'd1);
      check_eq("both_err_addr", err_addr, BASE + 64'h2000);
      set_rd(BASE + 64'd7);
      tick();
      check_eq("frozen_err_addr", err_addr, BASE + 64'h2000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
